// File: rtl/mem_arbiter.sv
// Line-memory arbiter: serialises I-cache refills, D-cache refills and D-cache
// write-backs onto a single line memory, one operation in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              Ic_req,
    input  logic [ADDR_W-1:0] Ic_addr,
    output logic [LINE_W-1:0] Ic_line,
    output logic              Ic_valid,

    input  logic              Dc_req,
    input  logic [ADDR_W-1:0] Dc_addr,
    output logic [LINE_W-1:0] Dc_line,
    output logic              Dc_valid,

    input  logic              Dc_wb_req,
    input  logic [ADDR_W-1:0] Dc_wb_addr,
    input  logic [LINE_W-1:0] Dc_wb_line,
    output logic              Dc_wb_ack,

    output logic              ARB_mem_req,
    output logic [ADDR_W-1:0] ARB_mem_addr,
    input  logic [LINE_W-1:0] MEM_data_line,
    input  logic              MEM_mem_valid,

    output logic              ARB_wb_we,
    output logic [ADDR_W-1:0] ARB_wb_addr,
    output logic [LINE_W-1:0] ARB_wb_wline,

    output logic              ARB_busy
);

    // Handshakes: each requester holds its req level until it sees its one-cycle
    // valid/ack pulse and drops req on that same edge; requests are only sampled
    // in IDLE, and the memory read valid is only honoured in RD_WAIT.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_e;

    state_e              state_q,    state_d;
    owner_e              rr_last_q,  rr_last_d;
    logic [LINE_W-1:0]   ic_line_q,  ic_line_d;
    logic [LINE_W-1:0]   dc_line_q,  dc_line_d;
    logic                ic_valid_q, ic_valid_d;
    logic                dc_valid_q, dc_valid_d;
    logic                wb_ack_q,   wb_ack_d;
    logic                mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                wb_we_q,    wb_we_d;
    logic [ADDR_W-1:0]   wb_addr_q,  wb_addr_d;
    logic [LINE_W-1:0]   wb_wline_q, wb_wline_d;
    logic                busy_q,     busy_d;
    logic                grant_dc;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        ic_line_d  = ic_line_q;
        dc_line_d  = dc_line_q;
        ic_valid_d = 1'b0;
        dc_valid_d = 1'b0;
        wb_ack_d   = 1'b0;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        wb_we_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_wline_d = wb_wline_q;

        // On a tie the requester that did not own the previous read wins.
        grant_dc = Dc_req && (!Ic_req || (rr_last_q == OWN_IC));

        case (state_q)
            ST_IDLE: begin
                if (Dc_wb_req) begin
                    wb_addr_d  = Dc_wb_addr;
                    wb_wline_d = Dc_wb_line;
                    wb_we_d    = 1'b1;
                    wb_ack_d   = 1'b1;
                    state_d    = ST_WB;
                end else if (Ic_req || Dc_req) begin
                    if (grant_dc) begin
                        rr_last_d  = OWN_DC;
                        mem_addr_d = Dc_addr;
                    end else begin
                        rr_last_d  = OWN_IC;
                        mem_addr_d = Ic_addr;
                    end
                    mem_req_d = 1'b1;
                    state_d   = ST_RD_ISSUE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (MEM_mem_valid) begin
                    if (rr_last_q == OWN_DC) begin
                        dc_line_d  = MEM_data_line;
                        dc_valid_d = 1'b1;
                    end else begin
                        ic_line_d  = MEM_data_line;
                        ic_valid_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= OWN_IC;
            ic_line_q  <= '0;
            dc_line_q  <= '0;
            ic_valid_q <= 1'b0;
            dc_valid_q <= 1'b0;
            wb_ack_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_wline_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            ic_line_q  <= ic_line_d;
            dc_line_q  <= dc_line_d;
            ic_valid_q <= ic_valid_d;
            dc_valid_q <= dc_valid_d;
            wb_ack_q   <= wb_ack_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_wline_q <= wb_wline_d;
            busy_q     <= busy_d;
        end
    end

    assign Ic_line      = ic_line_q;
    assign Ic_valid     = ic_valid_q;
    assign Dc_line      = dc_line_q;
    assign Dc_valid     = dc_valid_q;
    assign Dc_wb_ack    = wb_ack_q;
    assign ARB_mem_req  = mem_req_q;
    assign ARB_mem_addr = mem_addr_q;
    assign ARB_wb_we    = wb_we_q;
    assign ARB_wb_addr  = wb_addr_q;
    assign ARB_wb_wline = wb_wline_q;
    assign ARB_busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-3 line memory answers reads, and each
// step checks the arbiter's registered outputs against hand-computed values.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int LINE_W = 128;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              Ic_req = 1'b0;
    logic [ADDR_W-1:0] Ic_addr = '0;
    logic [LINE_W-1:0] Ic_line;
    logic              Ic_valid;
    logic              Dc_req = 1'b0;
    logic [ADDR_W-1:0] Dc_addr = '0;
    logic [LINE_W-1:0] Dc_line;
    logic              Dc_valid;
    logic              Dc_wb_req = 1'b0;
    logic [ADDR_W-1:0] Dc_wb_addr = '0;
    logic [LINE_W-1:0] Dc_wb_line = '0;
    logic              Dc_wb_ack;
    logic              ARB_mem_req;
    logic [ADDR_W-1:0] ARB_mem_addr;
    logic [LINE_W-1:0] MEM_data_line;
    logic              MEM_mem_valid;
    logic              ARB_wb_we;
    logic [ADDR_W-1:0] ARB_wb_addr;
    logic [LINE_W-1:0] ARB_wb_wline;
    logic              ARB_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .Ic_req        (Ic_req),
        .Ic_addr       (Ic_addr),
        .Ic_line       (Ic_line),
        .Ic_valid      (Ic_valid),
        .Dc_req        (Dc_req),
        .Dc_addr       (Dc_addr),
        .Dc_line       (Dc_line),
        .Dc_valid      (Dc_valid),
        .Dc_wb_req     (Dc_wb_req),
        .Dc_wb_addr    (Dc_wb_addr),
        .Dc_wb_line    (Dc_wb_line),
        .Dc_wb_ack     (Dc_wb_ack),
        .ARB_mem_req   (ARB_mem_req),
        .ARB_mem_addr  (ARB_mem_addr),
        .MEM_data_line (MEM_data_line),
        .MEM_mem_valid (MEM_mem_valid),
        .ARB_wb_we     (ARB_wb_we),
        .ARB_wb_addr   (ARB_wb_addr),
        .ARB_wb_wline  (ARB_wb_wline),
        .ARB_busy      (ARB_busy)
    );

    // Line memory: line[i] = {4{i}} until written; valid pulse after LAT edges.
    function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
        return {4{32'(a)}};
    endfunction

    bit                wr_flag [1024];
    logic [LINE_W-1:0] wr_data [1024];
    logic              mdl_valid = 1'b0;
    logic [LINE_W-1:0] mdl_line = '0;
    logic              pend = 1'b0;
    int                lat_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic              spur_valid = 1'b0;
    logic [LINE_W-1:0] spur_line = {4{32'hDEADBEEF}};

    assign MEM_mem_valid = mdl_valid | spur_valid;
    assign MEM_data_line = spur_valid ? spur_line : mdl_line;

    always @(posedge clk) begin
        if (ARB_wb_we) begin
            wr_flag[ARB_wb_addr] <= 1'b1;
            wr_data[ARB_wb_addr] <= ARB_wb_wline;
        end
        mdl_valid <= 1'b0;
        if (ARB_mem_req) begin
            pend      <= 1'b1;
            lat_cnt   <= LAT;
            pend_addr <= ARB_mem_addr;
        end else if (pend) begin
            if (lat_cnt == 1) begin
                mdl_valid <= 1'b1;
                mdl_line  <= wr_flag[pend_addr] ? wr_data[pend_addr] : init_line(pend_addr);
                pend      <= 1'b0;
            end
            lat_cnt <= lat_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with the requests already set up; returns in the
    // IDLE cycle after the response, with the served request dropped.
    task automatic do_read(input string tag, input bit is_dc, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] exp_line, input bit side_step);
        tick();
        chk({tag, "_mem_req"},  ARB_mem_req, 1);
        chk({tag, "_mem_addr"}, ARB_mem_addr, addr);
        chk({tag, "_busy"},     ARB_busy, 1);
        if (side_step) begin
            if (is_dc) begin
                Ic_req  = 1'b1;
                Ic_addr = 10'd8;
            end else begin
                Ic_addr = Ic_addr + 10'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_wait"}, {ARB_mem_req, Ic_valid, Dc_valid, ARB_busy}, 4'b0001);
        end
        tick();
        chk({tag, "_own_valid"},   is_dc ? Dc_valid : Ic_valid, 1);
        chk({tag, "_other_valid"}, is_dc ? Ic_valid : Dc_valid, 0);
        chk({tag, "_line"},        is_dc ? Dc_line : Ic_line, exp_line);
        if (is_dc) Dc_req = 1'b0;
        else       Ic_req = 1'b0;
        tick();
        chk({tag, "_idle"}, {ARB_busy, Ic_valid, Dc_valid}, 0);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy",    ARB_busy, 0);
        chk("rst_valids",  {Ic_valid, Dc_valid, Dc_wb_ack, ARB_mem_req, ARB_wb_we}, 0);
        chk("rst_ic_line", Ic_line, 0);
        chk("rst_dc_line", Dc_line, 0);
        chk("rst_addrs",   {ARB_mem_addr, ARB_wb_addr}, 0);
        chk("rst_wline",   ARB_wb_wline, 0);
        rst = 1'b0;

        // Single I-cache refill of line 5.
        Ic_req  = 1'b1;
        Ic_addr = 10'd5;
        do_read("ic5", 1'b0, 10'd5, 128'h00000005_00000005_00000005_00000005, 1'b0);

        // Repeated ties: Dc(7), Ic(2), Dc(7), Ic(2).
        Ic_req  = 1'b1;
        Ic_addr = 10'd2;
        Dc_req  = 1'b1;
        Dc_addr = 10'd7;
        do_read("tie1_dc", 1'b1, 10'd7, init_line(10'd7), 1'b0);
        Dc_req = 1'b1;
        do_read("tie2_ic", 1'b0, 10'd2, init_line(10'd2), 1'b0);
        Ic_req = 1'b1;
        do_read("tie3_dc", 1'b1, 10'd7, init_line(10'd7), 1'b0);
        Dc_req = 1'b1;
        do_read("tie4_ic", 1'b0, 10'd2, init_line(10'd2), 1'b0);
        Dc_req = 1'b0;

        // Write-back of line 7 beats the refill of line 7.
        Dc_wb_req  = 1'b1;
        Dc_wb_addr = 10'd7;
        Dc_wb_line = {32{4'hA}};
        Dc_req     = 1'b1;
        Dc_addr    = 10'd7;
        tick();
        chk("wb_we_ack",  {ARB_wb_we, Dc_wb_ack, ARB_mem_req, ARB_busy}, 4'b1101);
        chk("wb_addr",    ARB_wb_addr, 10'd7);
        chk("wb_wline",   ARB_wb_wline, {32{4'hA}});
        Dc_wb_req = 1'b0;
        tick();
        chk("wb_done",    {ARB_wb_we, Dc_wb_ack, ARB_mem_req, ARB_busy}, 4'b0000);
        do_read("wb_refill", 1'b1, 10'd7, {32{4'hA}}, 1'b0);

        // Spurious memory valid while IDLE.
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        chk("spur_idle_busy",   ARB_busy, 0);
        chk("spur_idle_valids", {Ic_valid, Dc_valid}, 0);
        chk("spur_idle_ic",     Ic_line, init_line(10'd2));
        chk("spur_idle_dc",     Dc_line, {32{4'hA}});
        tick();
        chk("spur_idle_busy2",  {ARB_busy, ARB_mem_req}, 0);

        // Spurious memory valid during a write-back.
        Dc_wb_req  = 1'b1;
        Dc_wb_addr = 10'd9;
        Dc_wb_line = {4{32'h12345678}};
        tick();
        chk("spur_wb_state", {ARB_busy, Dc_wb_ack, ARB_wb_we}, 3'b111);
        spur_valid = 1'b1;
        Dc_wb_req  = 1'b0;
        tick();
        spur_valid = 1'b0;
        chk("spur_wb_after", {ARB_busy, Ic_valid, Dc_valid, ARB_mem_req, Dc_wb_ack}, 0);
        chk("spur_wb_ic",    Ic_line, init_line(10'd2));
        chk("spur_wb_dc",    Dc_line, {32{4'hA}});
        tick();
        chk("spur_wb_idle",  ARB_busy, 0);

        // Reset during RD_WAIT; the late memory valid must be ignored.
        Ic_req  = 1'b1;
        Ic_addr = 10'd4;
        tick();
        chk("mrst_issue", ARB_mem_req, 1);
        tick();
        tick();
        chk("mrst_wait", {ARB_busy, ARB_mem_req}, 2'b10);
        rst    = 1'b1;
        Ic_req = 1'b0;
        tick();
        chk("mrst_flags",   {ARB_busy, Ic_valid, Dc_valid, Dc_wb_ack, ARB_mem_req, ARB_wb_we}, 0);
        chk("mrst_ic_line", Ic_line, 0);
        chk("mrst_dc_line", Dc_line, 0);
        chk("mrst_addrs",   {ARB_mem_addr, ARB_wb_addr}, 0);
        chk("mrst_wline",   ARB_wb_wline, 0);
        rst = 1'b0;
        tick();
        chk("mrst_mem_valid_seen", MEM_mem_valid, 1);
        tick();
        chk("mrst_late_valid", {ARB_busy, Ic_valid, Dc_valid}, 0);
        chk("mrst_late_line",  Ic_line, 0);
        Ic_req  = 1'b1;
        Ic_addr = 10'd5;
        do_read("post_rst", 1'b0, 10'd5, init_line(10'd5), 1'b0);

        // Ic rises while the Dc refill of line 3 is busy; Ic goes next and a
        // post-grant Ic address change is ignored.
        Dc_req  = 1'b1;
        Dc_addr = 10'd3;
        do_read("dc3", 1'b1, 10'd3, init_line(10'd3), 1'b1);
        do_read("ic_next", 1'b0, 10'd8, init_line(10'd8), 1'b1);
        chk("dc_line_hold", Dc_line, init_line(10'd3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
